fft_frame_streamer: RTL and testbench
=====================================

# fft_frame_streamer

Double-buffered frame source that drives the FFT-bin stream consumed by the loudness calculator. It accepts complex bins from the FFT core over a valid/ready interface with start/end-of-frame markers, which may be bursty or stalled. It stores each complete frame of `NSamples` bins, then replays it as one gap-free burst with `fft_valid` held high for exactly `NSamples` consecutive cycles. Partial or malformed frames are never emitted downstream.

## Interface
- `W`, 16, bit-width of each real/imag component
- `NSamples`, 1024, bins per frame (power of two, ≥4)
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input bin present
- `in_ready`  out  1  block can accept a bin this cycle
- `in_real`, `in_imag`  in  W each  input bin, two's complement
- `in_sop`  in  1  first bin of frame
- `in_eop`  in  1  last bin of frame
- `fft_valid`  out  1  output bin valid
- `fft_real`, `fft_imag`  out  W each  output bin
- `fft_sop`  out  1  high with first output bin of each frame
- `frame_err`  out  1  one-cycle pulse when an input frame is discarded
- `frames_pending`  out  2  count of full banks not yet streamed (0..2)

## Operation
- Two banks, each `NSamples` × 2W. Banks are written alternately and streamed in completion order.
- A bin transfers on any cycle with `in_valid && in_ready`.
- **Write FSM**
  - **W_IDLE**: `in_ready`=1 when a free bank exists. Transfers without `in_sop` are dropped silently. A transfer with `in_sop` writes index 0 and enters W_FILL.
  - **W_FILL**: each transfer writes at the next index.
  - Transfer at index `NSamples-1` with `in_eop` and no `in_sop`: bank marked full, `frames_pending`+1, return to W_IDLE.
  - Transfer with `in_eop` at an index below `NSamples-1`: frame discarded, `frame_err` pulses, return to W_IDLE.
  - Transfer at index `NSamples-1` without `in_eop`: same discard handling.
  - `in_sop` arriving during W_FILL: current frame discarded, `frame_err` pulses, and that bin is written as index 0 of the same bank. FSM stays in W_FILL.
- `in_ready`=0 whenever no bank is free: both banks full, or one full and the other streaming.
- **Read FSM**
  - **R_IDLE**: when `frames_pending`>0, go to R_PRIME.
  - **R_PRIME**: issue the RAM read of index 0 (synchronous RAM, 1-cycle read).
  - **R_STREAM**: emit one bin per cycle for indices 0..`NSamples-1` with no stalls.
  - After the last bin, the bank is freed, `frames_pending`−1, and the FSM returns to R_IDLE.
- Simultaneous events in one cycle (write completes, read frees a bank): both take effect; `frames_pending` nets to unchanged.
- Data passes bit-exact. No arithmetic is applied to samples.
- Index counters are `$clog2(NSamples)` bits and wrap to 0 at frame end.

## Timing
- Reset values (asserted asynchronously): `fft_valid`=0, `fft_real`=0, `fft_imag`=0, `fft_sop`=0, `frame_err`=0, `frames_pending`=0, `in_ready`=0.
- `in_ready` rises on the first clock edge after `reset_n` deasserts.
- Latency: final input bin accepted at edge T with reader idle. R_PRIME occurs in cycle T+1. First `fft_valid` (with `fft_sop`) appears in cycle T+2.
- Burst shape: `fft_valid` stays high for exactly `NSamples` cycles. `fft_sop` is high only in the first of them.
- Between consecutive frames, `fft_valid` is low for at least 1 cycle (the R_PRIME cycle), so the downstream accumulator window boundary is unambiguous.
- `fft_real`/`fft_imag` are registered outputs and hold 0 while `fft_valid`=0.
- `frame_err` is registered, asserted in the cycle after the offending transfer.
- Reset mid-frame: all banks are emptied, any partial burst is truncated, and no bin is emitted after reset.

## Test plan
- **Single clean frame**: `NSamples`=8, bins real=k, imag=−k for k=0..7, sop/eop correct, no stalls → 8 consecutive `fft_valid` cycles carrying identical values. First valid appears 2 cycles after eop. `fft_sop` high on k=0 only.
- **Bursty input**: same frame with `in_valid` toggled randomly → output still 8 contiguous valid cycles with data unchanged.
- **Backpressure**: 3 frames back-to-back while the reader streams → `in_ready` drops while both banks are occupied. `frames_pending` sequence is 1, 2, 1, 2, 1, 0. Outputs stay in order with a 1-cycle gap between bursts.
- **Short frame**: eop at index 5 (`NSamples`=8) → `frame_err` pulses once, nothing emitted. The next good frame streams normally.
- **Resync sop**: sop at index 3 mid-frame, followed by 7 more bins with eop → `frame_err` pulses once. The emitted frame is the bins starting from the resync sop.
- **Reset mid-stream**: assert `reset_n`=0 at output bin 4 → `fft_valid` goes 0 immediately and `frames_pending`=0. After release, no residual bins appear.

Source files
------------

// File: rtl/fft_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_streamer: double-buffered FFT bin store, replays whole frames    |
// | as gap-free bursts.  Revision: 1.0                                         |
// +----------------------------------------------------------------------------+
module fft_frame_streamer #(
  parameter int W        = 16,
  parameter int NSamples = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_imag,
  input  logic         in_sop,
  input  logic         in_eop,
  output logic         fft_valid,
  output logic [W-1:0] fft_real,
  output logic [W-1:0] fft_imag,
  output logic         fft_sop,
  output logic         frame_err,
  output logic [1:0]   frames_pending
);

  localparam int AW = $clog2(NSamples);
  localparam logic [AW-1:0] LAST = AW'(NSamples - 1);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_PRIME = 2'd1, R_STREAM = 2'd2} rstate_t;

  wstate_t       wstate_q, wstate_d;
  rstate_t       rstate_q, rstate_d;
  logic [AW-1:0] widx_q, widx_d, ridx_q, ridx_d, waddr_idx;
  logic          wbank_q, wbank_d, rbank_q, rbank_d;
  logic [1:0]    full_q, full_d;
  logic          alive_q, err_q, err_d, valid_q, sop_q, sop_d;
  logic [W-1:0]  real_q, imag_q;
  logic          accept, we, re, set_full, clr_full;

  logic [2*W-1:0] mem [2*NSamples];

  // Write bank is never full while filling, so a full write bank means no bank is free.
  assign in_ready = alive_q && !full_q[wbank_q];
  assign accept   = in_valid && in_ready;

  always_comb begin
    wstate_d  = wstate_q;
    widx_d    = widx_q;
    wbank_d   = wbank_q;
    waddr_idx = widx_q;
    we        = 1'b0;
    set_full  = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      case (wstate_q)
        W_IDLE: begin
          if (in_sop) begin
            we        = 1'b1;
            waddr_idx = '0;
            if (in_eop) begin
              err_d = 1'b1;
            end else begin
              widx_d   = AW'(1);
              wstate_d = W_FILL;
            end
          end
        end
        W_FILL: begin
          we = 1'b1;
          if (in_sop) begin
            waddr_idx = '0;
            widx_d    = AW'(1);
            err_d     = 1'b1;
          end else if (widx_q == LAST) begin
            widx_d   = '0;
            wstate_d = W_IDLE;
            if (in_eop) begin
              set_full = 1'b1;
              wbank_d  = ~wbank_q;
            end else begin
              err_d = 1'b1;
            end
          end else if (in_eop) begin
            widx_d   = '0;
            wstate_d = W_IDLE;
            err_d    = 1'b1;
          end else begin
            widx_d = widx_q + AW'(1);
          end
        end
        default: wstate_d = W_IDLE;
      endcase
    end
  end

  // The bank is released on its last read; the final bin still leaves via the output register.
  always_comb begin
    rstate_d = rstate_q;
    ridx_d   = ridx_q;
    rbank_d  = rbank_q;
    re       = 1'b0;
    sop_d    = 1'b0;
    clr_full = 1'b0;
    case (rstate_q)
      R_IDLE: if (full_q[rbank_q]) rstate_d = R_PRIME;
      R_PRIME: begin
        re       = 1'b1;
        sop_d    = 1'b1;
        ridx_d   = AW'(1);
        rstate_d = R_STREAM;
      end
      R_STREAM: begin
        re     = 1'b1;
        ridx_d = ridx_q + AW'(1);
        if (ridx_q == LAST) begin
          clr_full = 1'b1;
          rbank_d  = ~rbank_q;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wbank_q] = 1'b1;
    if (clr_full) full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wbank_q, waddr_idx}] <= {in_real, in_imag};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      widx_q   <= '0;
      ridx_q   <= '0;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      full_q   <= '0;
      alive_q  <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      real_q   <= '0;
      imag_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      widx_q   <= widx_d;
      ridx_q   <= ridx_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      full_q   <= full_d;
      alive_q  <= 1'b1;
      err_q    <= err_d;
      valid_q  <= re;
      sop_q    <= sop_d;
      if (re) begin
        {real_q, imag_q} <= mem[{rbank_q, ridx_q}];
      end else begin
        real_q <= '0;
        imag_q <= '0;
      end
    end
  end

  assign fft_valid      = valid_q;
  assign fft_sop        = sop_q;
  assign fft_real       = real_q;
  assign fft_imag       = imag_q;
  assign frame_err      = err_q;
  assign frames_pending = {full_q[0] & full_q[1], full_q[0] ^ full_q[1]};

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_frame_streamer: scoreboard bench for fft_frame_streamer, NSamples=8 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fft_frame_streamer;

  localparam int W  = 16;
  localparam int NS = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_real = '0;
  logic [W-1:0] in_imag = '0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic         fft_valid;
  logic [W-1:0] fft_real;
  logic [W-1:0] fft_imag;
  logic         fft_sop;
  logic         frame_err;
  logic [1:0]   frames_pending;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {sop, real, imag}.
  logic [2*W:0] sb[$];
  int           pend_log[$];
  int           pend_prev = 0;
  int           run = 0;
  int           gap = 0;
  int           err_pulses = 0;
  bit           chk_gap = 1'b0;
  bit           had_burst = 1'b0;
  bit           blocked = 1'b0;

  fft_frame_streamer #(.W(W), .NSamples(NS)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .in_sop(in_sop), .in_eop(in_eop),
    .fft_valid(fft_valid), .fft_real(fft_real), .fft_imag(fft_imag),
    .fft_sop(fft_sop), .frame_err(frame_err), .frames_pending(frames_pending)
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every valid bin and checks burst shape.
  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0;
      gap = 0;
      pend_prev = 0;
    end else begin
      if (fft_valid) begin
        if (run == 0 && chk_gap && had_burst) begin
          checks++;
          if (gap !== 1) begin
            errors++;
            $display("FAIL burst_gap: got %0d cycles, want 1", gap);
          end
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bin: got real=%0d imag=%0d with empty scoreboard", fft_real, fft_imag);
        end else begin
          logic [2*W:0] e;
          e = sb.pop_front();
          if ({fft_sop, fft_real, fft_imag} !== e) begin
            errors++;
            $display("FAIL out_bin: got sop=%0b re=%h im=%h, want sop=%0b re=%h im=%h",
                     fft_sop, fft_real, fft_imag, e[2*W], e[2*W-1:W], e[W-1:0]);
          end
        end
        run++;
        gap = 0;
      end else begin
        if (run != 0) begin
          checks++;
          if (run !== NS) begin
            errors++;
            $display("FAIL burst_len: got %0d, want %0d", run, NS);
          end
          had_burst = 1'b1;
          gap = 1;
        end else begin
          gap++;
        end
        run = 0;
        if (fft_real !== '0 || fft_imag !== '0 || fft_sop !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL idle_out: got re=%h im=%h sop=%0b, want zeros", fft_real, fft_imag, fft_sop);
        end
      end
      if (frame_err) err_pulses++;
      if (int'(frames_pending) != pend_prev) begin
        pend_log.push_back(int'(frames_pending));
        pend_prev = int'(frames_pending);
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic put(input logic s, input logic e, input logic [W-1:0] r, input logic [W-1:0] i);
    int t = 0;
    in_valid = 1'b1; in_sop = s; in_eop = e; in_real = r; in_imag = i;
    while (!in_ready && t < 200) begin
      blocked = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: in_ready low for %0d cycles, want high", t);
    end
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (t < 300) begin
      @(negedge clk); #2;
      if (sb.size() == 0 && !fft_valid && run == 0 && frames_pending == 2'd0) break;
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL drain_timeout: %0d bins left, want 0", sb.size());
    end
  endtask

  task automatic push_frame(input int base, input bit neg);
    for (int k = 0; k < NS; k++) begin
      logic [W-1:0] r, i;
      r = W'(base + k);
      i = neg ? W'(-(base + k)) : W'(base + k + 1000);
      sb.push_back({(k == 0), r, i});
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({fft_valid, fft_sop, frame_err, in_ready} !== 4'b0 || fft_real !== '0 ||
        fft_imag !== '0 || frames_pending !== 2'd0) begin
      errors++;
      $display("FAIL reset_vals: got v=%0b sop=%0b err=%0b rdy=%0b re=%h im=%h pend=%0d, want all 0",
               fft_valid, fft_sop, frame_err, in_ready, fft_real, fft_imag, frames_pending);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %0b, want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got %0b, want 1", in_ready);
    end
  endtask

  task automatic test_clean_frame();
    push_frame(0, 1'b1);
    for (int k = 0; k < NS; k++) put(k == 0, k == NS - 1, W'(k), W'(-k));
    // Now in the cycle after accepting edge T.
    checks++;
    if (fft_valid !== 1'b0) begin
      errors++; $display("FAIL latency_T: got valid=%0b, want 0", fft_valid);
    end
    @(negedge clk);
    checks++;
    if (fft_valid !== 1'b0) begin
      errors++; $display("FAIL latency_prime: got valid=%0b, want 0", fft_valid);
    end
    @(negedge clk);
    checks++;
    if (fft_valid !== 1'b1 || fft_sop !== 1'b1) begin
      errors++; $display("FAIL latency_first: got valid=%0b sop=%0b, want 1 1", fft_valid, fft_sop);
    end
    wait_idle();
    checks++;
    if (err_pulses !== 0) begin
      errors++; $display("FAIL clean_err: got %0d pulses, want 0", err_pulses);
    end
  endtask

  task automatic test_bursty();
    push_frame(20, 1'b1);
    for (int k = 0; k < NS; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      put(k == 0, k == NS - 1, W'(20 + k), W'(-(20 + k)));
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int exp_p[6] = '{1, 2, 1, 2, 1, 0};
    pend_log.delete();
    blocked   = 1'b0;
    chk_gap   = 1'b1;
    had_burst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      push_frame(400 + 16 * f, 1'b0);
      for (int k = 0; k < NS; k++)
        put(k == 0, k == NS - 1, W'(400 + 16 * f + k), W'(400 + 16 * f + k + 1000));
    end
    wait_idle();
    chk_gap = 1'b0;
    checks++;
    if (!blocked) begin
      errors++; $display("FAIL backpressure: got in_ready never low, want a stall");
    end
    checks++;
    if (pend_log.size() != 6) begin
      errors++; $display("FAIL pend_len: got %0d changes, want 6", pend_log.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (pend_log[j] != exp_p[j]) begin
          errors++; $display("FAIL pend_seq[%0d]: got %0d, want %0d", j, pend_log[j], exp_p[j]);
        end
      end
    end
  endtask

  task automatic test_short_frame();
    int e0;
    e0 = err_pulses;
    for (int k = 0; k < 6; k++) put(k == 0, k == 5, W'(50 + k), W'(60 + k));
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL short_err_pulse: got %0b, want 1", frame_err);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (err_pulses - e0 != 1 || frames_pending !== 2'd0) begin
      errors++; $display("FAIL short_discard: got pulses=%0d pend=%0d, want 1 0", err_pulses - e0, frames_pending);
    end
    push_frame(70, 1'b0);
    for (int k = 0; k < NS; k++) put(k == 0, k == NS - 1, W'(70 + k), W'(70 + k + 1000));
    wait_idle();
  endtask

  task automatic test_resync_sop();
    int e0;
    e0 = err_pulses;
    for (int k = 0; k < 3; k++) put(k == 0, 1'b0, W'(100 + k), W'(150 + k));
    push_frame(200, 1'b0);
    put(1'b1, 1'b0, W'(200), W'(1200));
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL resync_err_pulse: got %0b, want 1", frame_err);
    end
    for (int k = 1; k < NS; k++) put(1'b0, k == NS - 1, W'(200 + k), W'(200 + k + 1000));
    wait_idle();
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++; $display("FAIL resync_err_count: got %0d, want 1", err_pulses - e0);
    end
  endtask

  task automatic test_reset_mid_stream();
    int t = 0;
    push_frame(300, 1'b0);
    for (int k = 0; k < NS; k++) put(k == 0, k == NS - 1, W'(300 + k), W'(300 + k + 1000));
    while (t < 50) begin
      @(negedge clk); #2;
      if (run >= 4) break;
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++; $display("FAIL reset_wait: got run=%0d, want >=4", run);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (fft_valid !== 1'b0 || frames_pending !== 2'd0 || fft_real !== '0) begin
      errors++; $display("FAIL async_reset: got valid=%0b pend=%0d re=%h, want 0 0 0",
                         fft_valid, frames_pending, fft_real);
    end
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (frames_pending !== 2'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL after_reset: got pend=%0d rdy=%0b, want 0 1", frames_pending, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_bursty();
    test_back_to_back();
    test_short_frame();
    test_resync_sop();
    test_reset_mid_stream();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL leftover: got %0d bins pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
